// File: rtl/axi_pkg.sv
// Shared AXI3 write-path definitions: arbiter FSM states, burst/response
// encodings and channel field widths.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester
// that was not granted last wins. Purely combinational, one-hot result.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Select the winner from the request pair and the priority pointer
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-master AXI3 write-path arbiter. One transaction in flight at a time;
// the grant is held from AW handshake through the B handshake so bursts
// never interleave. The slave-side WLAST is regenerated from the beat count.
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int buswidth = 32,
  parameter int BEATW    = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // master 0 write address
  input  logic [ID_W-1:0]       M0_AWID,
  input  logic [ADDR_W-1:0]     M0_AWADDR,
  input  logic [LEN_W-1:0]      M0_AWLEN,
  input  logic [SIZE_W-1:0]     M0_AWSIZE,
  input  logic [1:0]            M0_AWBURST,
  input  logic [1:0]            M0_AWLOCK,
  input  logic [3:0]            M0_AWCACHE,
  input  logic [2:0]            M0_AWPROT,
  input  logic                  M0_AWVALID,
  output logic                  M0_AWREADY,
  // master 0 write data
  input  logic [ID_W-1:0]       M0_WID,
  input  logic [buswidth-1:0]   M0_WDATA,
  input  logic [buswidth/8-1:0] M0_WSTRB,
  input  logic                  M0_WLAST,
  input  logic                  M0_WVALID,
  output logic                  M0_WREADY,
  // master 0 write response
  output logic [ID_W-1:0]       M0_BID,
  output logic [1:0]            M0_BRESP,
  output logic                  M0_BVALID,
  input  logic                  M0_BREADY,
  // master 1 write address
  input  logic [ID_W-1:0]       M1_AWID,
  input  logic [ADDR_W-1:0]     M1_AWADDR,
  input  logic [LEN_W-1:0]      M1_AWLEN,
  input  logic [SIZE_W-1:0]     M1_AWSIZE,
  input  logic [1:0]            M1_AWBURST,
  input  logic [1:0]            M1_AWLOCK,
  input  logic [3:0]            M1_AWCACHE,
  input  logic [2:0]            M1_AWPROT,
  input  logic                  M1_AWVALID,
  output logic                  M1_AWREADY,
  // master 1 write data
  input  logic [ID_W-1:0]       M1_WID,
  input  logic [buswidth-1:0]   M1_WDATA,
  input  logic [buswidth/8-1:0] M1_WSTRB,
  input  logic                  M1_WLAST,
  input  logic                  M1_WVALID,
  output logic                  M1_WREADY,
  // master 1 write response
  output logic [ID_W-1:0]       M1_BID,
  output logic [1:0]            M1_BRESP,
  output logic                  M1_BVALID,
  input  logic                  M1_BREADY,
  // slave write address
  output logic [ID_W-1:0]       S_AWID,
  output logic [ADDR_W-1:0]     S_AWADDR,
  output logic [LEN_W-1:0]      S_AWLEN,
  output logic [SIZE_W-1:0]     S_AWSIZE,
  output logic [1:0]            S_AWBURST,
  output logic [1:0]            S_AWLOCK,
  output logic [3:0]            S_AWCACHE,
  output logic [2:0]            S_AWPROT,
  output logic                  S_AWVALID,
  input  logic                  S_AWREADY,
  // slave write data
  output logic [ID_W-1:0]       S_WID,
  output logic [buswidth-1:0]   S_WDATA,
  output logic [buswidth/8-1:0] S_WSTRB,
  output logic                  S_WLAST,
  output logic                  S_WVALID,
  input  logic                  S_WREADY,
  // slave write response
  input  logic [ID_W-1:0]       S_BID,
  input  logic [1:0]            S_BRESP,
  input  logic                  S_BVALID,
  output logic                  S_BREADY,
  // status
  output logic [1:0]            gnt,
  output logic                  len_err
);

  state_t             state;
  logic [1:0]         gnt_q;
  logic               last_q;
  logic [LEN_W-1:0]   len_q;
  logic [BEATW-1:0]   beat_q;
  logic               len_err_q;

  logic [1:0]         pick;
  logic               sel;

  // granted-master views of every master-driven field
  logic [ID_W-1:0]       aw_id;
  logic [ADDR_W-1:0]     aw_addr;
  logic [LEN_W-1:0]      aw_len;
  logic [SIZE_W-1:0]     aw_size;
  logic [1:0]            aw_burst;
  logic [1:0]            aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic [ID_W-1:0]       w_id;
  logic [buswidth-1:0]   w_data;
  logic [buswidth/8-1:0] w_strb;
  logic                  w_last;
  logic                  w_valid;
  logic                  b_ready;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic wlast_exp;

  rr_arb2 u_rr_arb2 (
    .req  ({M1_AWVALID, M0_AWVALID}),
    .last (last_q),
    .gnt  (pick)
  );

  // gnt_q is one-hot outside IDLE, so its upper bit is the granted index
  assign sel = gnt_q[1];

  assign aw_id    = sel ? M1_AWID    : M0_AWID;
  assign aw_addr  = sel ? M1_AWADDR  : M0_AWADDR;
  assign aw_len   = sel ? M1_AWLEN   : M0_AWLEN;
  assign aw_size  = sel ? M1_AWSIZE  : M0_AWSIZE;
  assign aw_burst = sel ? M1_AWBURST : M0_AWBURST;
  assign aw_lock  = sel ? M1_AWLOCK  : M0_AWLOCK;
  assign aw_cache = sel ? M1_AWCACHE : M0_AWCACHE;
  assign aw_prot  = sel ? M1_AWPROT  : M0_AWPROT;
  assign aw_valid = sel ? M1_AWVALID : M0_AWVALID;
  assign w_id     = sel ? M1_WID     : M0_WID;
  assign w_data   = sel ? M1_WDATA   : M0_WDATA;
  assign w_strb   = sel ? M1_WSTRB   : M0_WSTRB;
  assign w_last   = sel ? M1_WLAST   : M0_WLAST;
  assign w_valid  = sel ? M1_WVALID  : M0_WVALID;
  assign b_ready  = sel ? M1_BREADY  : M0_BREADY;

  assign wlast_exp = (beat_q == BEATW'(len_q));
  assign aw_hs     = (state == ST_ADDR) && aw_valid && S_AWREADY;
  assign w_hs      = (state == ST_DATA) && w_valid  && S_WREADY;
  assign b_hs      = (state == ST_RESP) && S_BVALID && b_ready;

  assign gnt     = gnt_q;
  assign len_err = len_err_q;

  // FSM, grant/priority pointer, burst length and beat counter, length check
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= 1'b1;
      len_q     <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (w_hs && (w_last != wlast_exp))
        len_err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          gnt_q <= pick;
          if (pick != 2'b00)
            state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (aw_hs) begin
            len_q  <= aw_len;
            beat_q <= '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + BEATW'(1);
            if (wlast_exp)
              state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            last_q <= sel;
            gnt_q  <= '0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Channel muxes: only the channel owned by the current state is forwarded,
  // everything else (including all of IDLE) drives zero
  always_comb begin
    S_AWID     = '0;
    S_AWADDR   = '0;
    S_AWLEN    = '0;
    S_AWSIZE   = '0;
    S_AWBURST  = '0;
    S_AWLOCK   = '0;
    S_AWCACHE  = '0;
    S_AWPROT   = '0;
    S_AWVALID  = 1'b0;
    M0_AWREADY = 1'b0;
    M1_AWREADY = 1'b0;
    S_WID      = '0;
    S_WDATA    = '0;
    S_WSTRB    = '0;
    S_WLAST    = 1'b0;
    S_WVALID   = 1'b0;
    M0_WREADY  = 1'b0;
    M1_WREADY  = 1'b0;
    S_BREADY   = 1'b0;
    M0_BID     = '0;
    M0_BRESP   = '0;
    M0_BVALID  = 1'b0;
    M1_BID     = '0;
    M1_BRESP   = '0;
    M1_BVALID  = 1'b0;
    case (state)
      ST_ADDR: begin
        S_AWID     = aw_id;
        S_AWADDR   = aw_addr;
        S_AWLEN    = aw_len;
        S_AWSIZE   = aw_size;
        S_AWBURST  = aw_burst;
        S_AWLOCK   = aw_lock;
        S_AWCACHE  = aw_cache;
        S_AWPROT   = aw_prot;
        S_AWVALID  = aw_valid;
        M0_AWREADY = !sel && S_AWREADY;
        M1_AWREADY = sel && S_AWREADY;
      end
      ST_DATA: begin
        S_WID     = w_id;
        S_WDATA   = w_data;
        S_WSTRB   = w_strb;
        S_WLAST   = wlast_exp;
        S_WVALID  = w_valid;
        M0_WREADY = !sel && S_WREADY;
        M1_WREADY = sel && S_WREADY;
      end
      ST_RESP: begin
        S_BREADY = b_ready;
        if (sel) begin
          M1_BID    = S_BID;
          M1_BRESP  = S_BRESP;
          M1_BVALID = S_BVALID;
        end else begin
          M0_BID    = S_BID;
          M0_BRESP  = S_BRESP;
          M0_BVALID = S_BVALID;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: single beat, tie-break, back-pressure,
// WLAST mismatch, reset mid-burst and response stall.
module tb_axi_write_arbiter;

  logic ACLK = 1'b0;
  logic ARESET;

  logic [1:0]       m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic [1:0]       m_bvalid, m_bready;
  logic [1:0][3:0]  m_awid, m_awlen, m_bid;
  logic [1:0][31:0] m_awaddr, m_wdata, m_base;
  logic [1:0][1:0]  m_bresp;

  logic [3:0]  S_AWID, S_AWLEN, S_AWCACHE, S_WID, S_WSTRB, S_BID;
  logic [31:0] S_AWADDR, S_WDATA;
  logic [2:0]  S_AWSIZE, S_AWPROT;
  logic [1:0]  S_AWBURST, S_AWLOCK, S_BRESP, gnt;
  logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY;
  logic        S_BVALID, S_BREADY, len_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.buswidth(32), .BEATW(5)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWID(m_awid[0]), .M0_AWADDR(m_awaddr[0]), .M0_AWLEN(m_awlen[0]),
    .M0_AWSIZE(3'd2), .M0_AWBURST(2'b01), .M0_AWLOCK(2'b00), .M0_AWCACHE(4'h3),
    .M0_AWPROT(3'd0), .M0_AWVALID(m_awvalid[0]), .M0_AWREADY(m_awready[0]),
    .M0_WID(m_awid[0]), .M0_WDATA(m_wdata[0]), .M0_WSTRB(4'hF),
    .M0_WLAST(m_wlast[0]), .M0_WVALID(m_wvalid[0]), .M0_WREADY(m_wready[0]),
    .M0_BID(m_bid[0]), .M0_BRESP(m_bresp[0]), .M0_BVALID(m_bvalid[0]),
    .M0_BREADY(m_bready[0]),
    .M1_AWID(m_awid[1]), .M1_AWADDR(m_awaddr[1]), .M1_AWLEN(m_awlen[1]),
    .M1_AWSIZE(3'd1), .M1_AWBURST(2'b10), .M1_AWLOCK(2'b01), .M1_AWCACHE(4'hA),
    .M1_AWPROT(3'd5), .M1_AWVALID(m_awvalid[1]), .M1_AWREADY(m_awready[1]),
    .M1_WID(m_awid[1]), .M1_WDATA(m_wdata[1]), .M1_WSTRB(4'h3),
    .M1_WLAST(m_wlast[1]), .M1_WVALID(m_wvalid[1]), .M1_WREADY(m_wready[1]),
    .M1_BID(m_bid[1]), .M1_BRESP(m_bresp[1]), .M1_BVALID(m_bvalid[1]),
    .M1_BREADY(m_bready[1]),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWLOCK(S_AWLOCK), .S_AWCACHE(S_AWCACHE),
    .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .gnt(gnt), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input int m, input logic [31:0] addr, input logic [3:0] len,
                     input logic [3:0] id, input logic [31:0] base);
    m_awaddr[m]  = addr;
    m_awlen[m]   = len;
    m_awid[m]    = id;
    m_base[m]    = base;
    m_awvalid[m] = 1'b1;
  endtask

  // Drives one full transaction of master m whose AWVALID is already high.
  // waited = cycles until the grant appeared; abort_at >= 0 resets on that beat.
  task automatic run_txn(input int m, input int bstall, input int abort_at,
                         input bit wtoggle, input int bad_beat, output int waited);
    int o, len, b, cyc;
    logic [1:0] g, rsp;
    o   = 1 - m;
    g   = (m == 0) ? 2'b01 : 2'b10;
    rsp = (m == 0) ? 2'b00 : 2'b10;
    len = int'(m_awlen[m]);
    waited = 0;
    S_AWREADY = 1'b1;
    @(negedge ACLK);
    while (gnt != g && waited < 40) begin
      @(posedge ACLK); #1;
      waited++;
      @(negedge ACLK);
    end
    chk("grant", gnt, g);
    chk("s_awvalid", S_AWVALID, 1);
    chk("s_awaddr", S_AWADDR, m_awaddr[m]);
    chk("s_awlen", S_AWLEN, m_awlen[m]);
    chk("s_awid", S_AWID, m_awid[m]);
    chk("s_awsize", S_AWSIZE, (m == 0) ? 3'd2 : 3'd1);
    chk("awready_own", m_awready[m], 1);
    chk("awready_other", m_awready[o], 0);
    @(posedge ACLK); #1;
    m_awvalid[m] = 1'b0;
    b = 0;
    cyc = 0;
    m_wvalid[m] = 1'b1;
    while (b <= len && cyc < 200) begin
      S_WREADY    = wtoggle ? logic'(cyc % 2 == 0) : 1'b1;
      m_wdata[m]  = m_base[m] + 32'(b);
      m_wlast[m]  = (bad_beat >= 0) ? (b == bad_beat) : (b == len);
      if (b == abort_at) begin
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("rst_gnt", gnt, 0);
        chk("rst_s_wvalid", S_WVALID, 0);
        chk("rst_s_wdata", S_WDATA, 0);
        chk("rst_wready", m_wready, 0);
        chk("rst_s_awvalid", S_AWVALID, 0);
        chk("rst_s_bready", S_BREADY, 0);
        chk("rst_len_err", len_err, 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        m_wvalid[m] = 1'b0;
        return;
      end
      @(negedge ACLK);
      chk("s_wvalid", S_WVALID, 1);
      chk("wready_mirror", m_wready[m], S_WREADY);
      chk("wready_other", m_wready[o], 0);
      if (S_WREADY) begin
        chk("s_wdata", S_WDATA, m_base[m] + 32'(b));
        chk("s_wlast", S_WLAST, (b == len));
        chk("s_wstrb", S_WSTRB, (m == 0) ? 4'hF : 4'h3);
      end
      @(posedge ACLK); #1;
      if (S_WREADY) b++;
      cyc++;
    end
    m_wvalid[m] = 1'b0;
    S_WREADY    = 1'b1;
    chk("beats", b, len + 1);
    S_BVALID = 1'b1;
    S_BID    = m_awid[m];
    S_BRESP  = rsp;
    m_bready[m] = (bstall > 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < bstall; i++) begin
      @(negedge ACLK);
      chk("stall_s_bready", S_BREADY, 0);
      chk("stall_bvalid", m_bvalid[m], 1);
      chk("stall_gnt", gnt, g);
      chk("stall_awready", m_awready, 0);
      @(posedge ACLK); #1;
    end
    m_bready[m] = 1'b1;
    @(negedge ACLK);
    chk("bvalid_own", m_bvalid[m], 1);
    chk("bid", m_bid[m], m_awid[m]);
    chk("bresp", m_bresp[m], rsp);
    chk("bvalid_other", m_bvalid[o], 0);
    chk("s_bready", S_BREADY, 1);
    @(posedge ACLK); #1;
    S_BVALID = 1'b0;
    @(negedge ACLK);
    chk("idle_gnt", gnt, 0);
    chk("idle_s_awvalid", S_AWVALID, 0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    ARESET = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    m_awid = '0; m_awlen = '0; m_awaddr = '0; m_wdata = '0; m_base = '0;
    S_BID = '0; S_BRESP = '0;
    // requests and slave readies active while reset is held
    m_awvalid[0] = 1'b1;
    S_AWREADY = 1'b1; S_WREADY = 1'b1; S_BVALID = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_gnt", gnt, 0);
    chk("reset_s_awvalid", S_AWVALID, 0);
    chk("reset_s_awaddr", S_AWADDR, 0);
    chk("reset_awready", m_awready, 0);
    chk("reset_s_bready", S_BREADY, 0);
    chk("reset_bvalid", m_bvalid, 0);
    chk("reset_s_wvalid", S_WVALID, 0);
    chk("reset_len_err", len_err, 0);
    @(posedge ACLK); #1;
    m_awvalid = '0; S_BVALID = 1'b0;
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // single-beat transaction from M0
    req(0, 32'h100, 4'd0, 4'h3, 32'hDEADBEEF);
    run_txn(0, 0, -1, 1'b0, -1, w);
    chk("bubble", w, 1);

    // simultaneous requests right after reset: M0 first, M1 next
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    req(0, 32'h2000, 4'd3, 4'h1, 32'h1000_0000);
    req(1, 32'h3000, 4'd3, 4'h9, 32'h2000_0000);
    run_txn(0, 0, -1, 1'b0, -1, w);
    chk("tie_m0_wait", w, 1);
    run_txn(1, 0, -1, 1'b0, -1, w);
    chk("m1_next_wait", w, 0);
    // M1 was last, so M0 wins the next tie
    req(0, 32'h2100, 4'd0, 4'h2, 32'h1100_0000);
    req(1, 32'h3100, 4'd0, 4'hA, 32'h2100_0000);
    run_txn(0, 0, -1, 1'b0, -1, w);
    chk("tie2_m0_wait", w, 1);
    run_txn(1, 0, -1, 1'b0, -1, w);
    chk("tie2_m1_wait", w, 0);

    // back-pressure on W
    req(0, 32'h4000, 4'd7, 4'h2, 32'hA000_0000);
    run_txn(0, 0, -1, 1'b1, -1, w);

    // early WLAST on beat 2 of 4; flag stays set afterwards
    chk("len_err_clear", len_err, 0);
    req(0, 32'h5000, 4'd3, 4'h5, 32'hB000_0000);
    run_txn(0, 0, -1, 1'b0, 1, w);
    chk("len_err_set", len_err, 1);
    req(0, 32'h6000, 4'd0, 4'h6, 32'hC000_0000);
    run_txn(0, 0, -1, 1'b0, -1, w);
    chk("len_err_sticky", len_err, 1);

    // reset during beat 5 of a 16-beat burst (M0 was last before this)
    req(0, 32'h7000, 4'd15, 4'h7, 32'hD000_0000);
    run_txn(0, 0, 5, 1'b0, -1, w);
    req(0, 32'h8000, 4'd0, 4'h8, 32'hE000_0000);
    req(1, 32'h9000, 4'd1, 4'h9, 32'hF000_0000);
    run_txn(0, 0, -1, 1'b0, -1, w);
    chk("post_rst_tie_m0", w, 1);

    // response stall on M1 with M0 waiting
    req(0, 32'hA000, 4'd0, 4'hB, 32'h1234_0000);
    run_txn(1, 10, -1, 1'b0, -1, w);
    chk("stall_m1_wait", w, 0);
    run_txn(0, 0, -1, 1'b0, -1, w);
    chk("after_stall_m0_wait", w, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Two-master arbiter for the AXI3 write path: it shares one slave-side write address, write data and write response channel set between two write masters (`WriteMaster` instances). Grants are round-robin per transaction. The grant is held from the AW handshake through the last W beat and the B handshake, so bursts never interleave. It sits between the master devices and the memory slave / interconnect port.

## Interface

**Parameters**
- `buswidth`, default 32: WDATA width.
- `BEATW`, default 5: width of the internal beat counter (holds AWLEN+1, up to 16).

**Ports**
- `ACLK` in, 1: single clock for everything.
- `ARESET` in, 1: synchronous, active-high reset, sampled on the ACLK rising edge.
- `M0_AW*` / `M1_AW*` in: AWID[3:0], AWADDR[31:0], AWLEN[3:0], AWSIZE[2:0], AWBURST[1:0], AWLOCK[1:0], AWCACHE[3:0], AWPROT[2:0], AWVALID; out: AWREADY.
- `M0_W*` / `M1_W*` in: WID[3:0], WDATA[buswidth], WSTRB[buswidth/8], WLAST, WVALID; out: WREADY.
- `M0_B*` / `M1_B*` out: BID[3:0], BRESP[1:0], BVALID; in: BREADY.
- `S_AW*` out: same AW fields plus AWVALID; in: S_AWREADY.
- `S_W*` out: WID, WDATA, WSTRB, WLAST, WVALID; in: S_WREADY.
- `S_B*` in: BID, BRESP, BVALID; out: S_BREADY.
- `gnt` out, 2: one-hot current grant. 00 when idle.
- `len_err` out, 1: sticky flag; master WLAST disagreed with the beat count. Cleared only by reset.

## Operation

- **States:** IDLE, ADDR, DATA, RESP. All are registered. Outputs are a combinational mux of the granted master, qualified by state.
- **IDLE**
  - Arbitrate among masters with AWVALID=1.
  - Priority pointer `last` names the master granted most recently; the other master wins ties.
  - If exactly one master requests, it wins.
  - Winner is registered into `gnt`; next state is ADDR. No request: stay in IDLE, `gnt`=00.
- **ADDR**
  - S_AW* = granted master's AW*. Granted AWREADY = S_AWREADY. Non-granted AWREADY = 0.
  - On S_AWVALID & S_AWREADY: latch `len` = AWLEN, clear the beat counter, go to DATA.
- **DATA**
  - S_WID/WDATA/WSTRB/WVALID come from the granted master. Granted WREADY = S_WREADY. Non-granted WREADY = 0.
  - S_WLAST is generated by the arbiter as (beat == len). The master's WLAST is not forwarded.
  - Each W handshake increments `beat`.
  - If master WLAST ≠ (beat == len) on any handshake beat, set `len_err`.
  - A handshake with beat == len goes to RESP.
- **RESP**
  - S_BREADY = granted master's BREADY.
  - Granted M_B* = S_B*. Non-granted BVALID = 0.
  - On S_BVALID & S_BREADY: set `last` to the granted index, clear `gnt`, go to IDLE.
- **Single transaction:** only one transaction is in flight at a time. No outstanding-transaction tracking and no ID remapping; BID passes through unchanged.
- **No stall timeout:** the arbiter waits indefinitely on any stalled handshake.

## Timing

- **Reset values** (the cycle after ARESET is sampled high):
  - state = IDLE, `gnt` = 00, `last` = 1 (so master 0 wins the first tie), beat = 0, `len_err` = 0.
  - All VALID/READY outputs on both sides are 0. Data and address outputs are 0.
- **Reset mid-burst:** abort immediately to the reset values. Slave-side recovery is the system's responsibility.
- **Latency:**
  - AWVALID rising in IDLE → S_AWVALID high on the next cycle (one-cycle arbitration bubble).
  - AW/W/B forwarding is combinational, so there is zero added latency within a state.
- **Back-to-back transactions:** B handshake → IDLE for one cycle → next ADDR. Minimum four cycles per single-beat transaction with all READYs high.
- **Handshake rules:** VALID/READY hold follows the masters and the slave. The arbiter never deasserts a forwarded VALID mid-handshake except on reset.
- **Simultaneous requests:** both AWVALID in IDLE → the master ≠ `last` wins. The loser's AWVALID stays high and is served next; no starvation.
- **Beat counter width:** AWLEN = 15 gives 16 beats; `beat` counts 0..15 without overflow.
- **Early WLAST from a master:** the transaction continues to len+1 beats and `len_err` is set. W beats arriving in ADDR are not accepted (WREADY = 0).

## Structure

- **Shared package `axi_pkg`:** state enum (IDLE/ADDR/DATA/RESP); BURST_FIXED/INCR/WRAP; RESP_OKAY/EXOKAY/SLVERR/DECERR; ID/LEN/SIZE widths.
- **Sub-module `rr_arb2`:** combinational 2-way round-robin pick from `req[1:0]` and `last`, returning a one-hot grant. Reusable for the read-side arbiter.
- **Top module:** state register, `gnt`/`last`/`len`/`beat` registers, `len_err`, and the channel muxes.

## Test plan

- **Single-beat transaction:** M0 sends AWADDR=0x100, AWLEN=0 with WDATA=0xDEADBEEF; all READYs high. Expect S_AWVALID at cycle 1, S_WVALID+S_WLAST at cycle 2, M0_BVALID with BRESP=00, `gnt`=00 afterwards, and M1 seeing no READY/VALID.
- **Simultaneous requests after reset:** M0 and M1 both request AWLEN=3. Expect M0 granted first (4 beats, S_WLAST on beat 4), then M1 granted after M0's B handshake; `last`=1 at the end.
- **Back-pressure:** S_WREADY toggling 1/0 during an AWLEN=7 burst. Expect exactly 8 beats in order 0..7, S_WLAST only on beat 8, and M0_WREADY mirroring S_WREADY.
- **Length mismatch:** master asserts WLAST on beat 2 of an AWLEN=3 burst. Expect `len_err`=1, 4 beats still forwarded, and the flag staying set through later transactions.
- **Reset mid-burst:** ARESET asserted during beat 5 of an AWLEN=15 burst. Expect all VALID/READY = 0 and `gnt`=00 the next cycle; after release, M0 wins a tie.
- **Response stall:** S_BVALID high with M1_BREADY=0 for 10 cycles. Expect the arbiter to hold RESP, S_BREADY=0, no new grant, and M0's request waiting.
